// File: rtl/led_fx_sequencer.sv
// LED effect sequencer: holds one duty value per PWM channel, runs scan/fill/breathe/off
// effects on step/decay ticks and streams the full duty table to the PWM bank after each update.
module led_fx_sequencer #(
    parameter int CHANNELS  = 18,
    parameter int DUTY_MAX  = 200,
    parameter int STEP_DIV  = 2500000,
    parameter int DECAY_DIV = 125000
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       wr_valid,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic [4:0] position,
    output logic       busy
);
    // state    | meaning
    // S_IDLE   | waiting for a pending step/decay tick
    // S_UPDATE | one cycle: apply effect (or mode-change clear), consume pending ticks
    // S_FLUSH  | write duty[0..CHANNELS-1] to the PWM bank over valid/ready

    localparam int         SW        = $clog2(STEP_DIV + 1);
    localparam int         DW        = $clog2(DECAY_DIV + 1);
    localparam logic [4:0] LAST      = 5'(CHANNELS - 1);
    localparam logic [7:0] DMAX      = 8'(DUTY_MAX);
    localparam logic [1:0] M_SCAN    = 2'd0;
    localparam logic [1:0] M_FILL    = 2'd1;
    localparam logic [1:0] M_BREATHE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_FLUSH} state_t;
    state_t r_state, w_next_state;

    logic [SW-1:0] r_step_cnt;
    logic [DW-1:0] r_decay_cnt;
    logic          r_step_pend, r_decay_pend;
    logic          w_step_tick, w_decay_tick;
    logic [7:0]    r_duty [CHANNELS];
    logic [4:0]    r_position, r_idx;
    logic          r_dir_up, r_fill, r_level_up;
    logic [7:0]    r_level;
    logic [1:0]    r_applied_mode;
    logic [4:0]    w_scan_next;
    logic [7:0]    w_level_next;

    assign w_step_tick  = enable && (r_step_cnt == SW'(STEP_DIV - 1));
    assign w_decay_tick = enable && (r_decay_cnt == DW'(DECAY_DIV - 1));
    assign w_scan_next  = r_dir_up ? r_position + 5'd1 : r_position - 5'd1;
    assign w_level_next = r_level_up ? r_level + 8'd1 : r_level - 8'd1;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_step_cnt  <= '0;
            r_decay_cnt <= '0;
        end else if (!enable) begin
            r_step_cnt  <= '0;
            r_decay_cnt <= '0;
        end else begin
            r_step_cnt  <= w_step_tick ? '0 : r_step_cnt + SW'(1);
            r_decay_cnt <= w_decay_tick ? '0 : r_decay_cnt + DW'(1);
        end
    end

    // A tick landing in the UPDATE cycle itself is a new event and must survive the clear.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_step_pend  <= 1'b0;
            r_decay_pend <= 1'b0;
        end else if (!enable) begin
            r_step_pend  <= 1'b0;
            r_decay_pend <= 1'b0;
        end else begin
            r_step_pend  <= w_step_tick  | (r_step_pend  & (r_state != S_UPDATE));
            r_decay_pend <= w_decay_tick | (r_decay_pend & (r_state != S_UPDATE));
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (enable && (r_step_pend || r_decay_pend || w_step_tick || w_decay_tick))
                          w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = S_FLUSH;
            S_FLUSH:  if (wr_ready && r_idx == LAST) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET)                              r_idx <= '0;
        else if (r_state == S_FLUSH && wr_ready) r_idx <= (r_idx == LAST) ? 5'd0 : r_idx + 5'd1;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
            r_position     <= '0;
            r_dir_up       <= 1'b1;
            r_fill         <= 1'b1;
            r_level        <= '0;
            r_level_up     <= 1'b1;
            r_applied_mode <= '0;
        end else if (r_state == S_UPDATE) begin
            if (mode != r_applied_mode) begin
                for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
                r_position     <= '0;
                r_dir_up       <= 1'b1;
                r_fill         <= 1'b1;
                r_level        <= '0;
                r_level_up     <= 1'b1;
                r_applied_mode <= mode;
            end else begin
                case (mode)
                    M_SCAN: begin
                        if (r_decay_pend)
                            for (int i = 0; i < CHANNELS; i++)
                                if (r_duty[i] != 8'd0) r_duty[i] <= r_duty[i] - 8'd1;
                        // Later NBA wins, so the freshly lit channel overrides its own decay.
                        if (r_step_pend) begin
                            r_duty[r_position] <= DMAX;
                            r_position         <= w_scan_next;
                            if (w_scan_next == LAST)      r_dir_up <= 1'b0;
                            else if (w_scan_next == 5'd0) r_dir_up <= 1'b1;
                        end
                    end
                    M_FILL: begin
                        if (r_step_pend) begin
                            r_duty[r_position] <= r_fill ? DMAX : 8'd0;
                            if (r_position == LAST) begin
                                r_position <= '0;
                                r_fill     <= ~r_fill;
                            end else begin
                                r_position <= r_position + 5'd1;
                            end
                        end
                    end
                    M_BREATHE: begin
                        if (r_decay_pend) begin
                            r_level <= w_level_next;
                            if (w_level_next == DMAX)      r_level_up <= 1'b0;
                            else if (w_level_next == 8'd0) r_level_up <= 1'b1;
                            for (int i = 0; i < CHANNELS; i++) r_duty[i] <= w_level_next;
                        end
                    end
                    default: begin
                        for (int i = 0; i < CHANNELS; i++) r_duty[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign wr_valid = (r_state == S_FLUSH);
    assign wr_addr  = r_idx;
    assign wr_data  = r_duty[r_idx];
    assign position = r_position;
    assign busy     = (r_state != S_IDLE);

endmodule
